lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- HD44780-compatible responder for the LCD side of the LCD_DATA/LCD_RW/LCD_EN/LCD_RS bus driven by the existing LCD controller.
- Decodes each write strobe into commands or DDRAM data writes.
- Keeps a 2x16 shadow of the display plus mode and status flags, exposed for on-chip self-check, 7-seg/VGA mirroring and simulation scoreboarding.

Parameters:
- CLR_BUSY_CYC, 82000: busy cycles after clear/home (1.64 ms at 50 MHz).
- CMD_BUSY_CYC, 2000: busy cycles after any other accepted write (40 us at 50 MHz).

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  reset, asynchronous, active-low
- LCD_DATA  in  8  bus data
- LCD_RW  in  1  1=read, 0=write
- LCD_EN  in  1  enable; transfer is captured on its falling edge
- LCD_RS  in  1  0=command, 1=data
- iRD_ADDR  in  5  shadow read address; 0-15 = line 1, 16-31 = line 2
- oRD_DATA  out  8  shadow char at iRD_ADDR, registered, 1-cycle latency
- oBUSY  out  1  HD44780 busy flag equivalent
- oAC  out  7  address counter
- oDISP_ON, oCURSOR_ON, oBLINK_ON  out  1 each  display control bits D/C/B
- oFUNC_8BIT, oFUNC_2LINE  out  1 each  function-set bits DL/N
- oWR_STB  out  1  one-cycle pulse per accepted transfer
- oERR  out  1  sticky protocol error, cleared only by reset

Behaviour:
- **Input sampling:** LCD_EN, LCD_RS, LCD_RW and LCD_DATA pass through a 2-flop synchronizer, then a third EN flop.
  - fall = en_d3 & ~en_d2.
  - RS/RW/DATA are taken from the d3 stage, i.e. the values present before the fall.
  - oWR_STB and the resulting state change are visible on the 3rd iCLK edge after EN is first sampled low.
- **Reset values:**
  - oBUSY=1, oAC=0, I/D=1, DL=1.
  - oDISP_ON, oCURSOR_ON, oBLINK_ON, oFUNC_2LINE, oERR, oWR_STB and oRD_DATA are all 0.
  - The FSM enters CLEAR.
- **FSM states: IDLE, CLEAR, BUSY.**
  - CLEAR: 5-bit index 0..31; writes 0x20 to each shadow entry (32 cycles), then goes to BUSY with count=CLR_BUSY_CYC-32.
  - BUSY: counter decrements to 0, then goes to IDLE.
  - oBUSY=1 in both CLEAR and BUSY.
- **Any fall while oBUSY=1:** transfer ignored, no oWR_STB, oERR<=1. This includes a fall arriving in the same cycle busy ends, because busy is evaluated before the new transfer.
- **RW=1:** reads are unsupported; the transfer is ignored and oERR<=1.
- **Command decode (RS=0), by highest set bit:**
  - 0x01 clear: AC=0, I/D=1, go to CLEAR.
  - 0x02/0x03 home: AC=0, BUSY with CLR_BUSY_CYC.
  - 0x04-0x07 entry mode: I/D=bit1; S=bit0 is stored and has no effect.
  - 0x08-0x0F display control: D=bit2, C=bit1, B=bit0.
  - 0x10-0x1F shift: if bit3=0, AC steps by +1 (bit2=1) or -1; if bit3=1 (display shift), no change.
  - 0x20-0x3F function set: DL=bit4, N=bit3.
  - 0x40-0x7F CGRAM address: sets cg_mode=1; following data writes are discarded and AC is unchanged.
  - 0x80-0xFF DDRAM address: AC=data[6:0], cg_mode=0.
- **Data write (RS=1, cg_mode=0):**
  - AC 0x00-0x0F writes shadow[AC]; AC 0x40-0x4F writes shadow[16+AC[3:0]].
  - Any other AC discards the data, but AC still steps.
- **AC stepping (2-line map):**
  - Increment: 0x27 wraps to 0x40, 0x67 wraps to 0x00.
  - Decrement: 0x00 wraps to 0x67, 0x40 wraps to 0x27.
  - A DDRAM-address value outside the valid ranges (0x28-0x3F, 0x68-0x7F) is loaded as given and steps normally; a following increment moves it to the next valid range start.
- **Busy length:** every accepted transfer other than clear/home enters BUSY with CMD_BUSY_CYC.
- **Mid-operation reset:** an asynchronous reset at any point, including mid-CLEAR, restarts CLEAR from index 0.

Decomposition:
- Package lcd_pkg holds:
  - command class masks: CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGADDR, DDADDR;
  - line bases 7'h00 and 7'h40, LINE_LEN=16, AC wrap limits 7'h27 and 7'h67;
  - CHAR_SPACE=8'h20;
  - the FSM state enum.
- Sub-module lcd_ddram: 32x8 storage with one synchronous write port and one registered read port.

Test Plan:
- Release reset, hold the bus idle -> oBUSY=1 for exactly CLR_BUSY_CYC cycles; every oRD_DATA read returns 0x20; oAC=0; oERR=0.
- Run the controller init sequence 0x038, 0x00C, 0x001, 0x006, 0x080 with 262142-cycle gaps -> DL=1, N=1, D=1, C=0, B=0, I/D=1, oAC=0; five oWR_STB pulses.
- Send the full 38-entry sequence (line 1 "MIT-UFPB-2016 :)", 0x0C0, line 2 "Circuitos Logico") -> reads 0-15 and 16-31 match; the final oAC is 0x50.
- Send 0x0A7 then data 0x41, 0x42 -> 0x41 is discarded (AC 0x27 is not a visible position); AC wraps to 0x40; shadow[16]=0x42; final oAC=0x41.
- Send 0x004 (decrement), 0x080, then data 0x58 -> shadow[0]=0x58; oAC=0x67.
- Issue a second EN fall 100 cycles after 0x001, and separately a fall with RW=1 -> transfer ignored, no oWR_STB, oERR=1; assert reset mid-CLEAR -> all outputs take their reset values and CLEAR restarts from index 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-compatible bus responder.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package lcd_pkg;

    // Command classes, identified by the highest set bit of the command byte
    localparam logic [7:0] CMD_CLR    = 8'h01;
    localparam logic [7:0] CMD_HOME   = 8'h02;
    localparam logic [7:0] CMD_ENTRY  = 8'h04;
    localparam logic [7:0] CMD_DISP   = 8'h08;
    localparam logic [7:0] CMD_SHIFT  = 8'h10;
    localparam logic [7:0] CMD_FUNC   = 8'h20;
    localparam logic [7:0] CMD_CGADDR = 8'h40;
    localparam logic [7:0] CMD_DDADDR = 8'h80;

    // Two-line DDRAM address map
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam int         SHADOW_DEPTH = 2 * LINE_LEN;
    localparam logic [6:0] AC_WRAP1   = 7'h27;
    localparam logic [6:0] AC_WRAP2   = 7'h67;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_BUSY
    } lcdState_t;

    // One bus sample as seen through the synchronizer chain
    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] dat;
    } lcdBus_t;

    // Address counter step on the 2-line map. Increments out of either
    // line's 40-char window (including positions loaded beyond it) land
    // on the start of the other line; decrements wrap at the line starts.
    function automatic logic [6:0] acStep(input logic [6:0] ac, input logic inc);
        logic [6:0] res;
        if (inc) begin
            if (ac >= AC_WRAP2)
                res = LINE1_BASE;
            else if (ac >= AC_WRAP1 && ac < LINE2_BASE)
                res = LINE2_BASE;
            else
                res = ac + 7'd1;
        end else begin
            if (ac == LINE1_BASE)
                res = AC_WRAP2;
            else if (ac == LINE2_BASE)
                res = AC_WRAP1;
            else
                res = ac - 7'd1;
        end
        return res;
    endfunction

    // Map an address counter value to a shadow slot: {visible, index}.
    // Only the first LINE_LEN positions of each line are shadowed.
    function automatic logic [5:0] ddramIndex(input logic [6:0] ac);
        logic [6:0] off1;
        logic [6:0] off2;
        logic [5:0] res;
        off1 = ac - LINE1_BASE;
        off2 = ac - LINE2_BASE;
        res  = '0;
        if (off1 < 7'(LINE_LEN))
            res = {1'b1, 1'b0, off1[3:0]};
        else if (off2 < 7'(LINE_LEN))
            res = {1'b1, 1'b1, off2[3:0]};
        return res;
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_ddram.sv
// 32x8 shadow of the two visible 16-char lines.
// Latency: write takes effect at the clock edge; read data registered, 1 cycle.
// Backpressure: none; one write and one read accepted every cycle.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       wrEn,
    input  logic [4:0] wrAddr,
    input  logic [7:0] wrData,
    input  logic [4:0] rdAddr,
    output logic [7:0] rdData
);

    logic [7:0] mem [0:SHADOW_DEPTH-1];

    // Storage array: no reset, the CLEAR sweep initialises every entry
    always_ff @(posedge iCLK) begin
        if (wrEn)
            mem[wrAddr] <= wrData;
    end

    // Registered read port; reads return the pre-write value on a collision
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            rdData <= '0;
        else
            rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style responder: decodes LCD bus writes into a shadow display and mode flags.
// Latency: state change and oWR_STB on the 3rd iCLK edge after EN is first sampled low.
// Backpressure: none on the bus; transfers arriving while busy are dropped and flagged in oERR.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int CLR_BUSY_CYC = 82000,
    parameter int CMD_BUSY_CYC = 2000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic [4:0] iRD_ADDR,
    output logic [7:0] oRD_DATA,
    output logic       oBUSY,
    output logic [6:0] oAC,
    output logic       oDISP_ON,
    output logic       oCURSOR_ON,
    output logic       oBLINK_ON,
    output logic       oFUNC_8BIT,
    output logic       oFUNC_2LINE,
    output logic       oWR_STB,
    output logic       oERR
);

    // Counter sized for the longer (clear/home) wait; CMD_BUSY_CYC must not exceed it
    localparam int CNT_W = $clog2(CLR_BUSY_CYC + 1);

    // Bus synchronizer: two metastability flops plus a third EN stage for edge detect
    logic    enD1, enD2, enD3;
    lcdBus_t busD1, busD2, busD3;
    logic    fall;

    // Registered state
    lcdState_t        state, stateNxt;
    logic [4:0]       clrIdx, clrIdxNxt;
    logic [CNT_W-1:0] busyCnt, busyCntNxt;
    logic [6:0]       ac, acNxt;
    logic             incMode, incModeNxt;
    logic             entryShiftUnused, entryShiftUnusedNxt;
    logic             dispOn, dispOnNxt;
    logic             cursorOn, cursorOnNxt;
    logic             blinkOn, blinkOnNxt;
    logic             func8bit, func8bitNxt;
    logic             func2line, func2lineNxt;
    logic             cgMode, cgModeNxt;
    logic             wrStb, wrStbNxt;
    logic             err, errNxt;

    // Shadow write port, driven by the CLEAR sweep or an accepted data write
    logic       ramWe;
    logic [4:0] ramWaddr;
    logic [7:0] ramWdat;
    logic [5:0] slot;
    logic [7:0] cmd;

    // Synchronize the asynchronous LCD bus into the iCLK domain
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            enD1  <= 1'b0;
            enD2  <= 1'b0;
            enD3  <= 1'b0;
            busD1 <= '0;
            busD2 <= '0;
            busD3 <= '0;
        end else begin
            enD1  <= LCD_EN;
            enD2  <= enD1;
            enD3  <= enD2;
            busD1 <= '{rs: LCD_RS, rw: LCD_RW, dat: LCD_DATA};
            busD2 <= busD1;
            busD3 <= busD2;
        end
    end

    // Transfer strobe: EN was high one stage ago and is now low
    assign fall = enD3 & ~enD2;
    assign cmd  = busD3.dat;

    // State register; reset lands in CLEAR so the shadow starts out as spaces
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state            <= ST_CLEAR;
            clrIdx           <= '0;
            busyCnt          <= '0;
            ac               <= LINE1_BASE;
            incMode          <= 1'b1;
            entryShiftUnused <= 1'b0;
            dispOn           <= 1'b0;
            cursorOn         <= 1'b0;
            blinkOn          <= 1'b0;
            func8bit         <= 1'b1;
            func2line        <= 1'b0;
            cgMode           <= 1'b0;
            wrStb            <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= stateNxt;
            clrIdx           <= clrIdxNxt;
            busyCnt          <= busyCntNxt;
            ac               <= acNxt;
            incMode          <= incModeNxt;
            entryShiftUnused <= entryShiftUnusedNxt;
            dispOn           <= dispOnNxt;
            cursorOn         <= cursorOnNxt;
            blinkOn          <= blinkOnNxt;
            func8bit         <= func8bitNxt;
            func2line        <= func2lineNxt;
            cgMode           <= cgModeNxt;
            wrStb            <= wrStbNxt;
            err              <= errNxt;
        end
    end

    // Next-state: busy sequencing, then transfer decode (only ever accepted from IDLE)
    always_comb begin
        stateNxt            = state;
        clrIdxNxt           = clrIdx;
        busyCntNxt          = busyCnt;
        acNxt               = ac;
        incModeNxt          = incMode;
        entryShiftUnusedNxt = entryShiftUnused;
        dispOnNxt           = dispOn;
        cursorOnNxt         = cursorOn;
        blinkOnNxt          = blinkOn;
        func8bitNxt         = func8bit;
        func2lineNxt        = func2line;
        cgModeNxt           = cgMode;
        wrStbNxt            = 1'b0;
        errNxt              = err;
        ramWe               = 1'b0;
        ramWaddr            = clrIdx;
        ramWdat             = CHAR_SPACE;
        slot                = ddramIndex(ac);

        case (state)
            ST_CLEAR: begin
                // One shadow entry per cycle; the sweep counts toward the clear busy time
                ramWe     = 1'b1;
                clrIdxNxt = clrIdx + 5'd1;
                if (clrIdx == 5'(SHADOW_DEPTH - 1)) begin
                    stateNxt   = ST_BUSY;
                    busyCntNxt = CNT_W'(CLR_BUSY_CYC - SHADOW_DEPTH);
                end
            end
            ST_BUSY: begin
                busyCntNxt = busyCnt - CNT_W'(1);
                if (busyCnt <= CNT_W'(1)) begin
                    stateNxt   = ST_IDLE;
                    busyCntNxt = '0;
                end
            end
            default: begin
                stateNxt = ST_IDLE;
            end
        endcase

        if (fall) begin
            // Busy is judged on the current state, so a fall in the last busy cycle is lost
            if (state != ST_IDLE || busD3.rw) begin
                errNxt = 1'b1;
            end else begin
                wrStbNxt   = 1'b1;
                stateNxt   = ST_BUSY;
                busyCntNxt = CNT_W'(CMD_BUSY_CYC);
                if (busD3.rs) begin
                    if (!cgMode) begin
                        ramWe    = slot[5];
                        ramWaddr = slot[4:0];
                        ramWdat  = busD3.dat;
                        acNxt    = acStep(ac, incMode);
                    end
                end else if (|(cmd & CMD_DDADDR)) begin
                    acNxt     = cmd[6:0];
                    cgModeNxt = 1'b0;
                end else if (|(cmd & CMD_CGADDR)) begin
                    cgModeNxt = 1'b1;
                end else if (|(cmd & CMD_FUNC)) begin
                    func8bitNxt  = cmd[4];
                    func2lineNxt = cmd[3];
                end else if (|(cmd & CMD_SHIFT)) begin
                    if (!cmd[3])
                        acNxt = acStep(ac, cmd[2]);
                end else if (|(cmd & CMD_DISP)) begin
                    dispOnNxt   = cmd[2];
                    cursorOnNxt = cmd[1];
                    blinkOnNxt  = cmd[0];
                end else if (|(cmd & CMD_ENTRY)) begin
                    incModeNxt          = cmd[1];
                    entryShiftUnusedNxt = cmd[0];
                end else if (|(cmd & CMD_HOME)) begin
                    acNxt      = LINE1_BASE;
                    busyCntNxt = CNT_W'(CLR_BUSY_CYC);
                end else if (|(cmd & CMD_CLR)) begin
                    acNxt      = LINE1_BASE;
                    incModeNxt = 1'b1;
                    stateNxt   = ST_CLEAR;
                    clrIdxNxt  = '0;
                end
            end
        end
    end

    lcd_ddram u_ddram (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .wrEn   (ramWe),
        .wrAddr (ramWaddr),
        .wrData (ramWdat),
        .rdAddr (iRD_ADDR),
        .rdData (oRD_DATA)
    );

    assign oBUSY       = (state != ST_IDLE);
    assign oAC         = ac;
    assign oDISP_ON    = dispOn;
    assign oCURSOR_ON  = cursorOn;
    assign oBLINK_ON   = blinkOn;
    assign oFUNC_8BIT  = func8bit;
    assign oFUNC_2LINE = func2line;
    assign oWR_STB     = wrStb;
    assign oERR        = err;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with shortened busy times.
module tb_lcd_bus_receiver;

    localparam int CLR = 200;
    localparam int CMD = 40;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic [7:0] LCD_DATA = 8'h00;
    logic       LCD_RW = 1'b0;
    logic       LCD_EN = 1'b0;
    logic       LCD_RS = 1'b0;
    logic [4:0] iRD_ADDR = 5'd0;
    logic [7:0] oRD_DATA;
    logic       oBUSY;
    logic [6:0] oAC;
    logic       oDISP_ON, oCURSOR_ON, oBLINK_ON, oFUNC_8BIT, oFUNC_2LINE, oWR_STB, oERR;

    lcd_bus_receiver #(.CLR_BUSY_CYC(CLR), .CMD_BUSY_CYC(CMD)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA),
        .oBUSY(oBUSY), .oAC(oAC), .oDISP_ON(oDISP_ON), .oCURSOR_ON(oCURSOR_ON),
        .oBLINK_ON(oBLINK_ON), .oFUNC_8BIT(oFUNC_8BIT), .oFUNC_2LINE(oFUNC_2LINE),
        .oWR_STB(oWR_STB), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int nVec = 0;
    int nMis = 0;
    int stbCnt = 0;

    always @(posedge iCLK) begin
        if (oWR_STB)
            stbCnt <= stbCnt + 1;
    end

    typedef struct {
        logic       rs;
        logic [7:0] dat;
        logic [6:0] expAc;
        logic [4:0] expFlags;   // {DL, N, D, C, B}
    } vec_t;

    vec_t vecs[$];
    logic [7:0] expShadow [0:31];
    string l1 = "MIT-UFPB-2016 :)";
    string l2 = "Circuitos Logico";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rs, input logic [7:0] dat, input logic [6:0] ac, input logic [4:0] fl);
        vec_t v;
        v.rs = rs; v.dat = dat; v.expAc = ac; v.expFlags = fl;
        vecs.push_back(v);
    endtask

    // One bus transfer: EN high for 4 cycles, then low for 4 (past the strobe edge)
    task automatic strobe(input logic rs, input logic rw, input logic [7:0] dat);
        @(negedge iCLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = dat; LCD_EN = 1'b1;
        repeat (4) @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic waitIdle(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge iCLK);
            if (!oBUSY) done = 1'b1;
        end
        check("idle_wait", 32'(done), 32'd1);
    endtask

    task automatic readChk(input logic [4:0] addr, input logic [7:0] exp);
        @(negedge iCLK);
        iRD_ADDR = addr;
        @(negedge iCLK);
        check($sformatf("shadow[%0d]", addr), 32'(oRD_DATA), 32'(exp));
    endtask

    task automatic waitStb(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge iCLK);
            if (oWR_STB) seen = 1'b1;
        end
    endtask

    // Assert reset, check reset outputs, release just after an edge and time the busy span
    task automatic doReset();
        int n = 0;
        bit done = 1'b0;
        @(negedge iCLK);
        iRST_N = 1'b0; LCD_EN = 1'b0; LCD_RW = 1'b0; LCD_RS = 1'b0;
        repeat (2) @(negedge iCLK);
        check("rst_busy", 32'(oBUSY), 32'd1);
        check("rst_ac", 32'(oAC), 32'd0);
        check("rst_flags", 32'({oFUNC_8BIT, oFUNC_2LINE, oDISP_ON, oCURSOR_ON, oBLINK_ON}), 32'b10000);
        check("rst_stb_err_rd", 32'({oWR_STB, oERR, oRD_DATA}), 32'd0);
        @(posedge iCLK);
        #1 iRST_N = 1'b1;
        for (int i = 0; i < CLR + 100 && !done; i++) begin
            @(negedge iCLK);
            if (oBUSY) n++;
            else done = 1'b1;
        end
        check("rst_busy_len", 32'(n), 32'(CLR));
        check("post_rst_err", 32'(oERR), 32'd0);
    endtask

    initial begin
        int s0;
        bit seen;

        // Power-up: busy span, cleared shadow
        doReset();
        check("post_rst_ac", 32'(oAC), 32'd0);
        for (int i = 0; i < 32; i++) readChk(5'(i), 8'h20);

        // Init sequence, both lines, wrap cases, decrement, shift/home/CGRAM
        addVec(0, 8'h38, 7'h00, 5'b11000);
        addVec(0, 8'h0C, 7'h00, 5'b11100);
        addVec(0, 8'h01, 7'h00, 5'b11100);
        addVec(0, 8'h06, 7'h00, 5'b11100);
        addVec(0, 8'h80, 7'h00, 5'b11100);
        for (int i = 0; i < 16; i++) addVec(1, l1[i], 7'(i + 1), 5'b11100);
        addVec(0, 8'hC0, 7'h40, 5'b11100);
        for (int i = 0; i < 16; i++) addVec(1, l2[i], 7'(8'h41 + i), 5'b11100);
        addVec(0, 8'hA7, 7'h27, 5'b11100);
        addVec(1, 8'h41, 7'h40, 5'b11100);
        addVec(1, 8'h42, 7'h41, 5'b11100);
        addVec(0, 8'h04, 7'h41, 5'b11100);
        addVec(0, 8'h80, 7'h00, 5'b11100);
        addVec(1, 8'h58, 7'h67, 5'b11100);
        addVec(0, 8'h14, 7'h00, 5'b11100);
        addVec(0, 8'h10, 7'h67, 5'b11100);
        addVec(0, 8'h1C, 7'h67, 5'b11100);
        addVec(0, 8'h02, 7'h00, 5'b11100);
        addVec(0, 8'h40, 7'h00, 5'b11100);
        addVec(1, 8'h55, 7'h00, 5'b11100);
        addVec(0, 8'h80, 7'h00, 5'b11100);

        for (int i = 0; i < 16; i++) expShadow[i] = l1[i];
        for (int i = 0; i < 16; i++) expShadow[16 + i] = l2[i];
        expShadow[0]  = 8'h58;
        expShadow[16] = 8'h42;

        foreach (vecs[k]) begin
            s0 = stbCnt;
            strobe(vecs[k].rs, 1'b0, vecs[k].dat);
            waitIdle(CLR + 50);
            check($sformatf("v%0d_stb", k), 32'(stbCnt - s0), 32'd1);
            check($sformatf("v%0d_ac", k), 32'(oAC), 32'(vecs[k].expAc));
            check($sformatf("v%0d_flags", k),
                  32'({oFUNC_8BIT, oFUNC_2LINE, oDISP_ON, oCURSOR_ON, oBLINK_ON}), 32'(vecs[k].expFlags));
        end
        check("table_err", 32'(oERR), 32'd0);
        for (int i = 0; i < 32; i++) readChk(5'(i), expShadow[i]);

        // Second fall 100 cycles into a clear is dropped
        strobe(0, 0, 8'h83);
        waitIdle(CLR + 50);
        s0 = stbCnt;
        strobe(0, 0, 8'h01);
        repeat (92) @(negedge iCLK);
        strobe(0, 0, 8'h8A);
        waitIdle(CLR + 50);
        check("busy_drop_stb", 32'(stbCnt - s0), 32'd1);
        check("busy_drop_err", 32'(oERR), 32'd1);
        check("busy_drop_ac", 32'(oAC), 32'd0);
        readChk(5'd0, 8'h20);

        // Read transfer is rejected
        doReset();
        s0 = stbCnt;
        strobe(0, 1, 8'h85);
        repeat (4) @(negedge iCLK);
        check("rw_stb", 32'(stbCnt - s0), 32'd0);
        check("rw_err", 32'(oERR), 32'd1);
        check("rw_busy", 32'(oBUSY), 32'd0);
        check("rw_ac", 32'(oAC), 32'd0);

        // Fall landing one cycle after busy ends is taken; one in the last busy cycle is dropped
        doReset();
        s0 = stbCnt;
        @(negedge iCLK);
        LCD_RS = 0; LCD_RW = 0; LCD_DATA = 8'h80; LCD_EN = 1'b1;
        repeat (4) @(negedge iCLK);
        LCD_EN = 1'b0;
        waitStb(seen);
        check("edge_first_stb", 32'(seen), 32'd1);
        LCD_DATA = 8'h85; LCD_EN = 1'b1;
        repeat (CMD - 2) @(negedge iCLK);
        LCD_EN = 1'b0;
        waitStb(seen);
        check("edge_accept_stb", 32'(seen), 32'd1);
        check("edge_accept_err", 32'(oERR), 32'd0);
        LCD_DATA = 8'h86; LCD_EN = 1'b1;
        repeat (CMD - 3) @(negedge iCLK);
        LCD_EN = 1'b0;
        repeat (8) @(negedge iCLK);
        waitIdle(CLR + 50);
        check("edge_stb_total", 32'(stbCnt - s0), 32'd2);
        check("edge_drop_err", 32'(oERR), 32'd1);
        check("edge_drop_ac", 32'(oAC), 32'h05);

        // Write a char, then reset in the middle of the following CLEAR sweep
        strobe(1, 0, 8'h58);
        waitIdle(CLR + 50);
        readChk(5'd5, 8'h58);
        @(negedge iCLK);
        iRST_N = 1'b0;
        @(posedge iCLK);
        #1 iRST_N = 1'b1;
        repeat (10) @(negedge iCLK);
        doReset();
        readChk(5'd5, 8'h20);
        readChk(5'd31, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
